uart_fifo_tx: RTL and testbench
===============================

UART_FIFO_TX -- requirements
Module: uart_fifo_tx

Interface
REQ-001 SHALL have parameter CLOCKS_PER_BIT, default 868, meaning clock cycles per UART bit period (legal range 2 or more).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning data bits per frame; this equals the width of the source FIFO.
REQ-003 SHALL have parameter PARITY, default 0, meaning 0 = none, 1 = even, 2 = odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop-bit count (legal values 1 or 2).
REQ-005 SHALL have port clock  in  1  single system clock; all logic is on its rising edge.
REQ-006 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port enable  in  1  when high, the block may start new frames.
REQ-008 SHALL have port fifo_empty  in  1  source FIFO empty flag.
REQ-009 SHALL have port fifo_data  in  DATA_WIDTH  source FIFO registered read data, valid on the cycle after fifo_pop.
REQ-010 SHALL have port fifo_pop  out  1  one-cycle pop request to the source FIFO.
REQ-011 SHALL have port tx  out  1  UART serial line; idles high.
REQ-012 SHALL have port busy  out  1  high in every state except IDLE.
REQ-013 SHALL have port frame_done  out  1  one-cycle pulse on the last cycle of the final stop bit.

Function
REQ-014 SHALL implement the states IDLE, FETCH, START, DATA, PARITY, and STOP.
REQ-015 IDLE: when enable=1 and fifo_empty=0, the block SHALL assert fifo_pop for exactly one cycle and go to FETCH; otherwise it SHALL stay in IDLE with fifo_pop=0.
REQ-016 FETCH: the block SHALL latch fifo_data into the shift register, compute the parity bit over the latched word, and go to START; tx stays 1.
REQ-017 Latency: if fifo_pop is high in cycle N, tx SHALL first go low in cycle N+2.
REQ-018 START: tx=0 for exactly CLOCKS_PER_BIT cycles.
REQ-019 DATA: the block SHALL send DATA_WIDTH bits LSB first, each held for exactly CLOCKS_PER_BIT cycles.
- A bit counter of width $clog2(DATA_WIDTH)+1 SHALL track the bits sent.
REQ-020 PARITY state: entered only when PARITY!=0; it SHALL send one bit for CLOCKS_PER_BIT cycles.
- Even parity: the XOR of the data bits.
- Odd parity: the inverse of that XOR.
REQ-021 STOP: tx=1 for STOP_BITS*CLOCKS_PER_BIT cycles, with frame_done=1 on the final cycle; the block SHALL then go to IDLE.
REQ-022 Back-to-back frames: with data available, the next fifo_pop SHALL occur in the first IDLE cycle, giving exactly 2 idle-high cycles between the stop bit and the next start bit.
REQ-023 The bit-period counter SHALL count 0..CLOCKS_PER_BIT-1 and wrap to 0 at each bit boundary.
- It SHALL be at least $clog2(CLOCKS_PER_BIT) bits wide.
- It SHALL never overflow.
REQ-024 Deasserting enable mid-frame SHALL NOT abort the frame; it only blocks the next pop from IDLE.
REQ-025 fifo_empty SHALL be ignored outside IDLE, and fifo_pop SHALL never be asserted outside IDLE.
REQ-026 tx, fifo_pop, busy and frame_done SHALL be registered outputs, free of glitches.

Reset
REQ-027 While resetn=0, the block SHALL immediately hold the following, independent of clock:
- state=IDLE
- tx=1
- fifo_pop=0
- busy=0
- frame_done=0
- all counters=0
- shift register=0
REQ-028 Reset asserted mid-frame SHALL discard the in-flight word without re-popping it; tx SHALL return high asynchronously.
REQ-029 After resetn rises, the first pop SHALL occur no earlier than the first rising clock edge.

Verification
REQ-030 Single frame: CLOCKS_PER_BIT=4, PARITY=0, FIFO holds 0xA5 -> fifo_pop is high for 1 cycle.
- tx low 2 cycles later.
- tx then carries the bits 1,0,1,0,0,1,0,1, each held 4 cycles.
- tx is high for 4 cycles, with frame_done on the last of them.
- busy is high for 42 cycles in total.
REQ-031 Back-to-back: FIFO holds 0x00 then 0xFF -> two frames are sent in order, with exactly 2 idle-high cycles between the stop bit and the second start bit, and exactly 2 fifo_pop pulses.
REQ-032 Parity: PARITY=1 with 0x07 -> parity bit = 1; PARITY=2 with 0x07 -> parity bit = 0; STOP_BITS=2 -> the stop level lasts 8 cycles.
REQ-033 Flow: fifo_empty=1 -> no pops and tx stays 1; enable=0 with data present -> no pops; enable dropped mid-frame -> the current frame completes and no further pop occurs.
REQ-034 Reset mid-frame: assert resetn=0 during DATA bit 3 -> tx=1, busy=0 and fifo_pop=0 immediately; after release with the FIFO non-empty, the next frame carries the next FIFO word, not the aborted one.

Source files
------------

// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx: pops words from a registered-read FIFO and sends each one as a UART frame.
// start bit, LSB-first data, optional parity, one or two stop bits; tx idles high.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | line high, waiting for enable with a non-empty FIFO
//   FETCH  | pop cycle, then the cycle the FIFO read data is captured
//   START  | start bit, line low
//   DATA   | data bits, LSB first
//   PARITY | optional parity bit
//   STOP   | stop bit(s), line high; frame_done on the very last cycle
module uart_fifo_tx #(
    parameter int CLOCKS_PER_BIT = 868,
    parameter int DATA_WIDTH     = 8,
    parameter int PARITY         = 0,
    parameter int STOP_BITS      = 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_pop,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_WIDTH) + 1;

    localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] STOP_LAST  = BIT_W'(STOP_BITS - 1);
    localparam logic             ODD_PARITY = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    par_bit_q, par_bit_d;
    logic                    tx_q, tx_d;
    logic                    fifo_pop_q, fifo_pop_d;
    logic                    busy_q, busy_d;
    logic                    frame_done_q, frame_done_d;

    logic                    bit_end;
    logic                    start_ok;
    logic [CNT_W-1:0]        baud_next;

    assign bit_end   = (baud_cnt_q == BAUD_LAST);
    assign baud_next = bit_end ? '0 : baud_cnt_q + 1'b1;
    assign start_ok  = enable && !fifo_empty;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            baud_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            tx_q         <= 1'b1;
            fifo_pop_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_cnt_q   <= baud_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            tx_q         <= tx_d;
            fifo_pop_q   <= fifo_pop_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        fifo_pop_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                if (start_ok) begin
                    state_d    = S_FETCH;
                    fifo_pop_d = 1'b1;
                end
            end
            // first cycle is the pop itself; read data is valid on the second
            S_FETCH: begin
                if (baud_cnt_q == '0) begin
                    baud_cnt_d = CNT_W'(1);
                end else begin
                    baud_cnt_d = '0;
                    shift_d    = fifo_data;
                    par_bit_d  = (^fifo_data) ^ ODD_PARITY;
                    state_d    = S_START;
                end
            end
            S_START: begin
                baud_cnt_d = baud_next;
                if (bit_end) begin
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                baud_cnt_d = baud_next;
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                baud_cnt_d = baud_next;
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            // a waiting word is popped on the stop->idle edge so only two idle cycles separate frames
            S_STOP: begin
                baud_cnt_d = baud_next;
                if (bit_end) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        bit_cnt_d = '0;
                        if (start_ok) begin
                            state_d    = S_FETCH;
                            fifo_pop_d = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
            end
        endcase
    end

    // outputs are decoded from the next state so the registered pins line up with state_q
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_bit_d;
            default:  tx_d = 1'b1;
        endcase
        busy_d       = (state_d != S_IDLE);
        frame_done_d = (state_d == S_STOP) && (baud_cnt_d == BAUD_LAST) &&
                       (bit_cnt_d == STOP_LAST);
    end

    assign tx         = tx_q;
    assign fifo_pop   = fifo_pop_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// tb_uart_fifo_tx: three parity/stop variants fed from a modelled registered-read FIFO;
// every received frame is compared against a scoreboard of the words pushed.
module tb_uart_fifo_tx;

    localparam int CPB = 4;
    localparam int DW  = 8;

    logic           clk = 1'b0;
    logic           resetn;
    logic           enable;
    logic [1:0]     sel;
    logic [DW-1:0]  fifo_data_r = '0;
    logic [DW-1:0]  mem [0:63];
    int             wr_ptr = 0;
    int             rd_ptr = 0;
    int             underflow = 0;
    logic           model_empty;
    logic [2:0]     empty_v, pop_v, tx_v, busy_v, fd_v;
    logic           pop_s, tx_s, busy_s, fd_s;
    int             cyc = 0;

    int             n_checks = 0;
    int             n_errors = 0;
    logic [DW-1:0]  exp_q [$];

    logic           mon_active = 1'b0;
    int             off = 0;
    int             flen = 0;
    int             gap = 0;
    int             last_end_cyc = 0;
    int             last_pop_cyc = 0;
    int             busy_cnt = 0;
    int             pop_cnt = 0;
    int             pop_other = 0;
    int             frames_seen = 0;
    logic [63:0]    obs = '0;
    logic [63:0]    obs_fd = '0;
    logic [63:0]    last_obs = '0;
    logic           par_obs = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign model_empty = (wr_ptr == rd_ptr);
    assign empty_v[0]  = (sel == 2'd0) ? model_empty : 1'b1;
    assign empty_v[1]  = (sel == 2'd1) ? model_empty : 1'b1;
    assign empty_v[2]  = (sel == 2'd2) ? model_empty : 1'b1;
    assign pop_s  = (sel == 2'd0) ? pop_v[0]  : (sel == 2'd1) ? pop_v[1]  : pop_v[2];
    assign tx_s   = (sel == 2'd0) ? tx_v[0]   : (sel == 2'd1) ? tx_v[1]   : tx_v[2];
    assign busy_s = (sel == 2'd0) ? busy_v[0] : (sel == 2'd1) ? busy_v[1] : busy_v[2];
    assign fd_s   = (sel == 2'd0) ? fd_v[0]   : (sel == 2'd1) ? fd_v[1]   : fd_v[2];

    uart_fifo_tx #(.CLOCKS_PER_BIT(CPB), .DATA_WIDTH(DW), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clock(clk), .resetn(resetn), .enable(enable), .fifo_empty(empty_v[0]),
        .fifo_data(fifo_data_r), .fifo_pop(pop_v[0]), .tx(tx_v[0]), .busy(busy_v[0]),
        .frame_done(fd_v[0]));

    uart_fifo_tx #(.CLOCKS_PER_BIT(CPB), .DATA_WIDTH(DW), .PARITY(1), .STOP_BITS(2)) u_dut1 (
        .clock(clk), .resetn(resetn), .enable(enable), .fifo_empty(empty_v[1]),
        .fifo_data(fifo_data_r), .fifo_pop(pop_v[1]), .tx(tx_v[1]), .busy(busy_v[1]),
        .frame_done(fd_v[1]));

    uart_fifo_tx #(.CLOCKS_PER_BIT(CPB), .DATA_WIDTH(DW), .PARITY(2), .STOP_BITS(1)) u_dut2 (
        .clock(clk), .resetn(resetn), .enable(enable), .fifo_empty(empty_v[2]),
        .fifo_data(fifo_data_r), .fifo_pop(pop_v[2]), .tx(tx_v[2]), .busy(busy_v[2]),
        .frame_done(fd_v[2]));

    // source FIFO: read data appears the cycle after a pop
    always @(posedge clk) begin
        if (pop_s) begin
            if (rd_ptr != wr_ptr) begin
                fifo_data_r <= mem[rd_ptr % 64];
                rd_ptr      <= rd_ptr + 1;
            end else begin
                underflow <= underflow + 1;
            end
        end
    end

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int par_mode(input logic [1:0] s);
        return (s == 2'd1) ? 1 : (s == 2'd2) ? 2 : 0;
    endfunction

    function automatic int stop_cnt(input logic [1:0] s);
        return (s == 2'd1) ? 2 : 1;
    endfunction

    function automatic int frame_len(input logic [1:0] s);
        return (1 + DW + ((par_mode(s) != 0) ? 1 : 0) + stop_cnt(s)) * CPB;
    endfunction

    function automatic logic [63:0] exp_bits(input logic [DW-1:0] w, input logic [1:0] s);
        logic [63:0] v;
        int          b;
        v = '0;
        for (int o = 0; o < frame_len(s); o++) begin
            b = o / CPB;
            if (b == 0)
                v[o] = 1'b0;
            else if (b <= DW)
                v[o] = w[b-1];
            else if (par_mode(s) != 0 && b == DW + 1)
                v[o] = (^w) ^ (par_mode(s) == 2);
            else
                v[o] = 1'b1;
        end
        return v;
    endfunction

    task automatic push_word(input logic [DW-1:0] w);
        mem[wr_ptr % 64] = w;
        exp_q.push_back(w);
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k;
        k = 0;
        while (frames_seen < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk_eq("frames_seen", 64'(frames_seen), 64'(n));
    endtask

    task automatic wait_pops(input int n, input int budget);
        int k;
        k = 0;
        while (pop_cnt < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk_eq("pops_seen", 64'(pop_cnt), 64'(n));
    endtask

    // receiver: captures every cycle of a frame from its start edge
    initial begin
        logic [DW-1:0] w;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                mon_active = 1'b0;
                off        = 0;
            end else begin
                if (busy_s) busy_cnt++;
                if (pop_s) begin
                    pop_cnt++;
                    last_pop_cyc = cyc;
                end
                for (int i = 0; i < 3; i++)
                    if (pop_v[i] && (i != int'(sel))) pop_other++;
                if (!mon_active && tx_s == 1'b0) begin
                    mon_active = 1'b1;
                    off        = 0;
                    obs        = '0;
                    obs_fd     = '0;
                    flen       = frame_len(sel);
                    gap        = cyc - last_end_cyc;
                    chk_eq("start_latency", 64'(cyc - last_pop_cyc), 64'd2);
                end
                if (mon_active) begin
                    obs[off]    = tx_s;
                    obs_fd[off] = fd_s;
                    off++;
                    if (off == flen) begin
                        mon_active   = 1'b0;
                        last_end_cyc = cyc;
                        frames_seen++;
                        last_obs = obs;
                        par_obs  = obs[(1 + DW) * CPB + CPB / 2];
                        chk_eq("exp_avail", 64'(exp_q.size() != 0), 64'd1);
                        if (exp_q.size() != 0) begin
                            w = exp_q.pop_front();
                            chk_eq("frame_bits", obs, exp_bits(w, sel));
                            chk_eq("frame_done", obs_fd, 64'd1 << (flen - 1));
                        end
                    end
                end
            end
        end
    end

    initial begin
        int k;
        resetn = 1'b0;
        enable = 1'b0;
        sel    = 2'd0;
        repeat (2) @(negedge clk);
        chk_eq("rst_tx", 64'(tx_s), 64'd1);
        chk_eq("rst_busy", 64'(busy_s), 64'd0);
        chk_eq("rst_pop", 64'(pop_s), 64'd0);
        chk_eq("rst_frame_done", 64'(fd_s), 64'd0);
        #2 resetn = 1'b1;

        // empty FIFO: nothing happens
        enable = 1'b1;
        repeat (20) @(negedge clk);
        chk_eq("empty_no_pop", 64'(pop_cnt), 64'd0);
        chk_eq("empty_no_frame", 64'(frames_seen), 64'd0);

        // data present but disabled
        enable = 1'b0;
        push_word(8'hA5);
        repeat (20) @(negedge clk);
        chk_eq("disabled_no_pop", 64'(pop_cnt), 64'd0);

        // single frame
        busy_cnt = 0;
        enable   = 1'b1;
        wait_frames(1, 200);
        repeat (10) @(negedge clk);
        chk_eq("busy_cycles", 64'(busy_cnt), 64'd42);
        chk_eq("single_pops", 64'(pop_cnt), 64'd1);

        // back-to-back
        push_word(8'h00);
        push_word(8'hFF);
        wait_frames(3, 300);
        chk_eq("b2b_gap", 64'(gap), 64'd3);
        repeat (10) @(negedge clk);
        chk_eq("b2b_pops", 64'(pop_cnt), 64'd3);

        // enable dropped mid-frame
        push_word(8'h3C);
        push_word(8'h11);
        wait_pops(4, 100);
        repeat (10) @(negedge clk);
        enable = 1'b0;
        wait_frames(4, 300);
        repeat (30) @(negedge clk);
        chk_eq("drop_pops", 64'(pop_cnt), 64'd4);
        chk_eq("drop_left", 64'(wr_ptr - rd_ptr), 64'd1);

        // reset during data bit 3 of the 0x11 frame
        push_word(8'h5A);
        enable = 1'b1;
        k = 0;
        while (!(mon_active && off == 18) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk_eq("reached_bit3", 64'(off), 64'd18);
        #2 resetn = 1'b0;
        #1;
        chk_eq("midrst_tx", 64'(tx_s), 64'd1);
        chk_eq("midrst_busy", 64'(busy_s), 64'd0);
        chk_eq("midrst_pop", 64'(pop_s), 64'd0);
        void'(exp_q.pop_front());
        repeat (3) @(negedge clk);
        #2 resetn = 1'b1;
        wait_frames(5, 300);
        repeat (10) @(negedge clk);
        chk_eq("rst_pops", 64'(pop_cnt), 64'd6);
        chk_eq("fifo_drained", 64'(wr_ptr - rd_ptr), 64'd0);

        // even parity, two stop bits
        sel      = 2'd1;
        busy_cnt = 0;
        push_word(8'h07);
        wait_frames(6, 300);
        repeat (10) @(negedge clk);
        chk_eq("par_even_bit", 64'(par_obs), 64'd1);
        chk_eq("stop2_bits", 64'(last_obs[47:40]), 64'hFF);
        chk_eq("busy_p1s2", 64'(busy_cnt), 64'd50);

        // odd parity
        sel      = 2'd2;
        busy_cnt = 0;
        push_word(8'h07);
        wait_frames(7, 300);
        repeat (10) @(negedge clk);
        chk_eq("par_odd_bit", 64'(par_obs), 64'd0);
        chk_eq("busy_p2s1", 64'(busy_cnt), 64'd46);

        chk_eq("unselected_pops", 64'(pop_other), 64'd0);
        chk_eq("pop_underflow", 64'(underflow), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
